// File: rtl/g_mux_pkg.sv
// g_mux_pkg: shared constants and helpers for the arbitrated mux and its arbiter.
//   ARB_RR / ARB_FIXED : arbitration mode encodings
//   sel_w(n)           : index width for n channels, never below 1
package g_mux_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/g_arbiter.sv
// g_arbiter: round-robin or fixed-priority arbiter with one-hot grant and index.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : request vector, one bit per channel
//   en           : grant permitted this cycle
//   adv          : a granted transfer happened; move the round-robin pointer
//   grant        : one-hot grant, zero when en is low or nobody requests
//   grant_idx    : index of the selected requester
module g_arbiter import g_mux_pkg::*; #(
    parameter  int CHANNELS = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                en,
    input  logic                adv,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;
    logic [SEL_W-1:0] nxt_ptr;
    logic             hi_hit;
    logic             lo_hit;

    assign start = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;

    // Two-pass search avoids a rotating index: the lowest requester at or
    // above the pointer wins, else the lowest requester overall (the wrap).
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_hit = 1'b1;
                lo_idx = SEL_W'(i);
            end
            if (req[i] && i >= int'(start)) begin
                hi_hit = 1'b1;
                hi_idx = SEL_W'(i);
            end
        end
        grant_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < CHANNELS; i++)
            grant[i] = en && lo_hit && (grant_idx == SEL_W'(i));
    end

    // Explicit wrap so non-power-of-two channel counts return to 0.
    assign nxt_ptr = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (adv && ARB_MODE == ARB_RR)
            rr_ptr <= nxt_ptr;
    end

endmodule

// File: rtl/g_mux_arb.sv
// g_mux_arb: N-channel registered mux with valid/ready handshakes and internal arbitration.
//   clk, reset_n         : clock, synchronous active-low reset
//   in_data/in_valid     : per-channel words and offers (channel i at [i*WIDTH +: WIDTH])
//   in_ready             : one-hot (or zero) take strobe per channel
//   out_data/out_chan    : registered selected word and its source channel
//   out_valid/out_ready  : output handshake
module g_mux_arb import g_mux_pkg::*; #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int ARB_MODE = ARB_RR,
    localparam int SEL_W    = sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic             can_load;
    logic             load;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;

    // Gating with reset_n keeps in_ready low during reset.
    assign can_load = reset_n && (!out_valid || out_ready);

    g_arbiter #(
        .CHANNELS (CHANNELS),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (in_valid),
        .en        (can_load),
        .adv       (load),
        .grant     (in_ready),
        .grant_idx (grant_idx)
    );

    // Grant already implies the matching in_valid, so any grant is a transfer.
    assign load = |in_ready;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{in_ready[i]}});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/g_mux_arb.md
# g_mux_arb

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and built-in arbitration, successor to the fixed 16-bit two-input gate-level mux. It merges several producer streams onto one consumer stream. Examples are multiple masters contending for a shared Hack data-memory or I/O port, and debug/CPU paths onto the screen-RAM write port. Selection is made by an internal arbiter rather than an external `sel` line. The chosen word is held in a one-entry output register until the consumer accepts it.

## Interface

Parameters:
- `WIDTH`, 16: data width of every channel and of the output.
- `CHANNELS`, 4: number of input channels, 1..16.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- `SEL_W`, derived localparam: max(1, clog2(CHANNELS)).

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `in_data` in CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid` in CHANNELS: channel i offers a word.
- `in_ready` out CHANNELS: one-hot or zero; channel i's word is taken this cycle.
- `out_data` out WIDTH: registered selected word.
- `out_chan` out SEL_W: index of the channel that supplied `out_data`.
- `out_valid` out 1: output register holds an unaccepted word.
- `out_ready` in 1: consumer accepts the word this cycle.

## Operation

- The input transfer on channel i is `in_valid[i] & in_ready[i]`. The output transfer is `out_valid & out_ready`.
- Load enable: `can_load = !out_valid | out_ready`.
- Grant: when `can_load` is high, the arbiter selects one requesting channel g.
  - `in_ready` is the one-hot of g.
  - Otherwise `in_ready` is all zero.
  - `in_ready` never asserts for a channel whose `in_valid` is low.
- Round-robin (`ARB_MODE`=0):
  - The search starts at pointer `rr_ptr` and walks upward, wrapping at CHANNELS-1 → 0.
  - After each input transfer from g, `rr_ptr` ← (g+1) mod CHANNELS.
  - Non-power-of-two CHANNELS wraps correctly; e.g. for CHANNELS=3, g=2 → `rr_ptr`=0.
- Fixed priority (`ARB_MODE`=1): the lowest-index requester wins. `rr_ptr` is held at 0.
- Input transfer: `out_data` ← channel g word, `out_chan` ← g, `out_valid` ← 1.
- Output transfer with no input transfer in the same cycle: `out_valid` ← 0. `out_data` and `out_chan` hold their last values.
- Simultaneous output and input transfer: the register reloads and `out_valid` stays 1. Back-to-back words incur no bubble.
- No requesters and an output transfer: `out_valid` drops to 0 next cycle.
- `in_valid` dropping without a transfer is legal; a channel withdrawing its request loses nothing.
- CHANNELS=1: the block degenerates to a one-entry pipeline register. `out_chan` is constant 0.

## Timing

- Reset (`reset_n`=0 at a clock edge): `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=0.
  - `in_ready` is forced to 0 while `reset_n` is low.
  - Reset mid-operation discards the held word with no transfer reported.
- Latency: 1 cycle, from the input transfer edge to `out_valid` high.
- Throughput: 1 word per cycle while `out_ready` is held high.
- Combinational paths:
  - `out_ready` → `in_ready`, and `in_valid` → `in_ready`, through the arbiter only.
  - No combinational path to `out_data`, `out_valid` or `out_chan`.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_chan` are stable.

## Structure

- Shared package `g_mux_pkg`:
  - `ARB_RR`=0 and `ARB_FIXED`=1 constants.
  - A function computing `SEL_W` from a channel count.
- Sub-module `g_arbiter`, parametrised by CHANNELS and ARB_MODE:
  - Inputs: request vector, enable, advance.
  - Outputs: one-hot grant and grant index.
  - Owns `rr_ptr`.
  - Reusable by other shared-port blocks.
- The top level holds the output register and the W-bit N:1 select, built as an AND-OR of one-hot grant against the channel words.

## Test plan

- Reset then idle: hold `reset_n`=0 for 2 cycles with all `in_valid`=1 → `in_ready`=0, `out_valid`=0, `out_data`=0. Release → ch0 granted first cycle; `out_chan`=0 one cycle later.
- Round-robin fairness: CHANNELS=4, all valid continuously, `out_ready`=1 → `out_chan` sequence 0,1,2,3,0,1… with `out_valid` high every cycle after the first.
- Backpressure: ch2 sends 0xBEEF, `out_ready`=0 for 5 cycles → `out_data`=0xBEEF and `out_chan`=2 stable; `in_ready`=0 throughout. Raising `out_ready` accepts it and grants the next requester in the same cycle.
- Fixed priority: `ARB_MODE`=1, ch1 and ch3 valid continuously, `out_ready`=1 → ch1 wins every cycle; ch3 `in_ready` never asserts.
- Non-power-of-two wrap: CHANNELS=3, only ch2 then ch0 valid → after the ch2 transfer `rr_ptr`=0, and ch0 is granted next.
- Reset mid-stream: assert `reset_n`=0 while `out_valid`=1 with data 0x1234 → next cycle `out_valid`=0 and `out_data`=0; no transfer of 0x1234 is observed.
